// File: rtl/imem_boot_ctrl_if.sv
// Boot loader bundle: framed byte stream in, IMEM byte write port and core status out.
// The loader takes the slave view; whatever feeds the stream and watches the status takes master.
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              boot_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;

    modport master (
        output s_valid, s_data, boot_req,
        input  s_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err
    );

    modport slave (
        input  s_valid, s_data, boot_req,
        output s_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot-time IMEM loader: parses LEN_LO, LEN_HI, payload, CSUM from a byte stream,
// writes the payload into IMEM and releases the core only on a checksum match.
module imem_boot_ctrl #(
    parameter int MEM_BYTES      = 128,
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input logic             clk,
    input logic             rst,
    imem_boot_ctrl_if.slave bus
);
    localparam int              LEN_W   = $clog2(MEM_BYTES + 1);
    localparam logic [15:0]     LEN_MAX = 16'(MEM_BYTES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic [7:0]        csum;
    logic [TO_W-1:0]   to_cnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;

    logic              ready;
    logic              accept;
    logic              timed;
    logic [15:0]       len_full;
    logic              len_bad;

    // Ready is a pure function of state so the source never sees a valid->ready loop.
    assign ready    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
    assign accept   = bus.s_valid && ready;
    assign timed    = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CSUM);
    assign len_full = {bus.s_data, len_lo};
    assign len_bad  = (len_full == 16'd0) || (len_full > LEN_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN_LO;
            len_lo    <= '0;
            len       <= '0;
            cnt       <= '0;
            csum      <= '0;
            to_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            // Idle watchdog once a frame has started; an accept on the
            // expiring cycle still counts and restarts the window.
            if (timed) begin
                if (accept) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LAST) begin
                    to_cnt   <= '0;
                    state    <= S_ERR;
                    load_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            unique case (state)
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.s_data;
                        state  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        if (len_bad) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            len   <= len_full[LEN_W-1:0];
                            cnt   <= '0;
                            csum  <= '0;
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt[ADDR_W-1:0];
                        mem_wdata <= bus.s_data;
                        csum      <= csum + bus.s_data;
                        cnt       <= cnt + 1'b1;
                        if (cnt == len - 1'b1)
                            state <= S_CSUM;
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        if (bus.s_data == csum) begin
                            state     <= S_RUN;
                            core_hold <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.boot_req) begin
                        state     <= S_LEN_LO;
                        core_hold <= 1'b1;
                        load_done <= 1'b0;
                        cnt       <= '0;
                        csum      <= '0;
                        to_cnt    <= '0;
                    end
                end

                S_ERR: begin
                    core_hold <= 1'b1;
                    if (bus.boot_req) begin
                        state    <= S_LEN_LO;
                        load_err <= 1'b0;
                        cnt      <= '0;
                        csum     <= '0;
                        to_cnt   <= '0;
                    end
                end

                default: state <= S_ERR;
            endcase
        end
    end

    assign bus.s_ready   = ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.core_hold = core_hold;
    assign bus.load_done = load_done;
    assign bus.load_err  = load_err;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized bench for imem_boot_ctrl against a frame-level model of the boot protocol.
module tb_imem_boot_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_ctrl_if #(.ADDR_W(7)) bus ();

    imem_boot_ctrl #(
        .MEM_BYTES(128), .ADDR_W(7), .TIMEOUT_CYCLES(16), .TO_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // {s_ready, core_hold, load_done, load_err}
    function automatic int st();
        return int'({bus.s_ready, bus.core_hold, bus.load_done, bus.load_err});
    endfunction

    localparam int ST_LOAD = 4'b1100;
    localparam int ST_RUN  = 4'b0010;
    localparam int ST_ERR  = 4'b0101;

    // Write monitor: every IMEM write must follow a cycle with an accepted byte.
    logic [6:0] wr_a[$];
    logic [7:0] wr_d[$];
    int         gap_we   = 0;
    bit         acc_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
            if (!acc_prev) gap_we++;
        end
        acc_prev = bus.s_valid && bus.s_ready && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit rnd_req, output bit acc);
        repeat (gap) begin
            bus.s_valid  = 1'b0;
            bus.s_data   = 8'($urandom);
            bus.boot_req = rnd_req ? 1'($urandom) : 1'b0;
            tick();
        end
        bus.s_valid  = 1'b1;
        bus.s_data   = b;
        bus.boot_req = rnd_req ? 1'($urandom) : 1'b0;
        acc = bus.s_ready;
        tick();
        bus.s_valid  = 1'b0;
        bus.boot_req = 1'b0;
    endtask

    function automatic int pick_gap(input int gmax);
        if (gmax == 0 || $urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(1, gmax));
    endfunction

    task automatic reboot();
        bus.boot_req = 1'b1;
        tick();
        bus.boot_req = 1'b0;
        chk("reboot_st", st(), ST_LOAD);
    endtask

    // Reference: a length outside 1..128 errors right after LEN_HI with no writes;
    // otherwise payload byte i lands at address i, and the core runs iff the
    // trailing byte equals the payload sum mod 256.
    task automatic run_frame(input string tag, input logic [15:0] len, input logic [7:0] pl[$],
                             input bit bad_sum, input int gmax, input bit rnd_req);
        logic [7:0] sum;
        bit         acc;
        bit         len_ok;
        int         nacc;
        int         nexp;
        int         nbad;
        sum    = 8'd0;
        nacc   = 0;
        nbad   = 0;
        len_ok = (len != 16'd0) && (len <= 16'd128);
        foreach (pl[i]) sum += pl[i];
        wr_a.delete();
        wr_d.delete();
        gap_we = 0;

        send(len[7:0], pick_gap(gmax), rnd_req, acc);   nacc += int'(acc);
        send(len[15:8], pick_gap(gmax), rnd_req, acc);  nacc += int'(acc);
        nexp = 2;
        if (len_ok) begin
            foreach (pl[i]) begin
                send(pl[i], pick_gap(gmax), rnd_req, acc);
                nacc += int'(acc);
            end
            chk({tag, "/pre_csum_st"}, st(), ST_LOAD);
            send(bad_sum ? sum + 8'd1 : sum, pick_gap(gmax), rnd_req, acc);
            nacc += int'(acc);
            nexp = int'(len) + 3;
        end
        chk({tag, "/accepted"}, nacc, nexp);
        chk({tag, "/wr_count"}, wr_a.size(), len_ok ? int'(len) : 0);
        for (int i = 0; i < wr_a.size(); i++)
            if (i >= pl.size() || wr_a[i] != 7'(i) || wr_d[i] != pl[i]) nbad++;
        chk({tag, "/wr_content"}, nbad, 0);
        chk({tag, "/gap_we"}, gap_we, 0);
        chk({tag, "/status"}, st(), (len_ok && !bad_sum) ? ST_RUN : ST_ERR);
    endtask

    logic [7:0]  pl[$];
    logic [15:0] rlen;
    bit          acc;
    int          k;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
        bus.boot_req = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_st", st(), ST_LOAD);
        chk("rst_we", int'(bus.mem_we), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);

        // Known-good 4-byte frame, back-to-back bytes.
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_frame("t1", 16'h0004, pl, 1'b0, 0, 1'b0);

        // RUN ignores the stream.
        wr_a.delete();
        bus.s_valid = 1'b1;
        repeat (5) begin bus.s_data = 8'($urandom); tick(); end
        bus.s_valid = 1'b0;
        chk("run_ignore_wr", wr_a.size(), 0);
        chk("run_ignore_st", st(), ST_RUN);
        reboot();

        // Same frame, wrong checksum.
        run_frame("t2", 16'h0004, pl, 1'b1, 0, 1'b0);
        reboot();

        // Oversized length, then maximum length.
        pl.delete();
        run_frame("t3_len129", 16'h0081, pl, 1'b0, 0, 1'b0);
        reboot();
        run_frame("t3_len0", 16'h0000, pl, 1'b0, 0, 1'b0);
        reboot();
        for (int i = 0; i < 128; i++) pl.push_back(8'($urandom));
        run_frame("t3_len128", 16'h0080, pl, 1'b0, 0, 1'b0);
        if (wr_a.size() > 0) chk("t3_last_addr", int'(wr_a[wr_a.size()-1]), 127);
        reboot();

        // Stall after 2 payload bytes: error lands exactly 16 cycles after last accept.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        send(8'h08, 0, 1'b0, acc);
        send(8'h00, 0, 1'b0, acc);
        send(pl[0], 0, 1'b0, acc);
        send(pl[1], 0, 1'b0, acc);
        k = 0;
        while (k < 40 && bus.s_ready) begin tick(); k++; end
        chk("t4_to_cycles", k, 16);
        chk("t4_to_st", st(), ST_ERR);
        reboot();

        // Same stall, byte arrives on the expiring cycle.
        begin
            logic [7:0] s;
            s = 8'd0;
            foreach (pl[i]) s += pl[i];
            send(8'h08, 0, 1'b0, acc);
            send(8'h00, 0, 1'b0, acc);
            send(pl[0], 0, 1'b0, acc);
            send(pl[1], 0, 1'b0, acc);
            send(pl[2], 15, 1'b0, acc);
            chk("t4_late_acc", int'(acc), 1);
            chk("t4_late_st", st(), ST_LOAD);
            for (int i = 3; i < 8; i++) send(pl[i], 0, 1'b0, acc);
            send(s, 0, 1'b0, acc);
            chk("t4_late_done", st(), ST_RUN);
        end
        reboot();

        // Random frames with valid gaps and stray boot_req during loading.
        for (int it = 0; it < 10; it++) begin
            bit bs;
            pl.delete();
            bs = ($urandom_range(0, 3) == 0) && (it != 0);
            if (it == 0)                           rlen = 16'd8;
            else if ($urandom_range(0, 9) == 0)    rlen = ($urandom_range(0, 1) == 0) ? 16'd0
                                                          : 16'($urandom_range(129, 65535));
            else                                   rlen = 16'($urandom_range(1, 128));
            if (rlen != 16'd0 && rlen <= 16'd128)
                for (int i = 0; i < int'(rlen); i++) pl.push_back(8'($urandom));
            run_frame($sformatf("t5_%0d", it), rlen, pl, bs, 3, 1'b1);
            reboot();
        end

        // Reset in the middle of a payload, then a fresh frame.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        send(8'h08, 0, 1'b0, acc);
        send(8'h00, 0, 1'b0, acc);
        for (int i = 0; i < 4; i++) send(pl[i], 0, 1'b0, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_st", st(), ST_LOAD);
        chk("t6_rst_we", int'(bus.mem_we), 0);
        chk("t6_rst_addr", int'(bus.mem_addr), 0);
        chk("t6_rst_wdata", int'(bus.mem_wdata), 0);
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_frame("t6_fresh", 16'h0008, pl, 1'b0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
